// File: rtl/mem_definitions.sv
// rtl/mem_definitions.sv - shared memory-access types and store lane helpers
package mem_definitions;

    typedef enum logic [2:0] {
        MEM_BYTE  = 3'd0,
        MEM_HALF  = 3'd1,
        MEM_WORD  = 3'd2,
        MEM_UBYTE = 3'd3,
        MEM_UHALF = 3'd4
    } mem_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    function automatic logic is_misaligned(input mem_mask_t kind, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (kind)
            MEM_HALF, MEM_UHALF: bad = offset[0];
            MEM_WORD:            bad = (offset != 2'b00);
            default:             bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input mem_mask_t kind, input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b1111;
        case (kind)
            MEM_BYTE, MEM_UBYTE: be = 4'b0001 << offset;
            MEM_HALF, MEM_UHALF: be = offset[1] ? 4'b1100 : 4'b0011;
            default:             be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the right-justified store data so every lane carries it.
    function automatic logic [31:0] lane_data(input mem_mask_t kind, input logic [31:0] wdata);
        logic [31:0] data;
        data = wdata;
        case (kind)
            MEM_BYTE, MEM_UBYTE: data = {4{wdata[7:0]}};
            MEM_HALF, MEM_UHALF: data = {2{wdata[15:0]}};
            default:             data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// rtl/dmem_bank_ram.sv - single-port byte-write data RAM with synchronous read-first output
module dmem_bank_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // rdata returns the word as it was before any write in the same access.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-stage data responder with fixed wait states and error checks
module dmem_responder
    import mem_definitions::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  mem_mask_t   m_mem_type,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        stall_mem,
    output logic [31:0] read_data,
    output logic        resp_valid,
    output logic        access_err
);

    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    dmem_state_t       state;
    logic [3:0]        wait_cnt;
    logic              req;
    logic              range_err;
    logic              req_err;
    logic              do_access;
    logic              data_ok;
    logic [31:0]       ram_q;

    logic [ADDR_W-1:0] acc_addr;
    logic [3:0]        acc_be;
    logic [31:0]       acc_data;
    logic              acc_err;

    assign req       = m_MemRead | m_MemWrite;
    assign stall_mem = req & (state != ST_DONE);
    assign range_err = (m_addr >> (ADDR_W + 2)) != 32'd0;
    assign req_err   = range_err | is_misaligned(m_mem_type, m_addr[1:0]);
    assign do_access = (state == ST_WAIT) && (wait_cnt == 4'd0) && !rst;
    assign read_data = data_ok ? ram_q : 32'd0;

    // Capture the request at acceptance so a protocol violation mid-wait still completes it.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            acc_addr <= m_addr[ADDR_W+1:2];
            acc_be   <= (m_MemWrite && !req_err) ? lane_be(m_mem_type, m_addr[1:0]) : 4'b0000;
            acc_data <= lane_data(m_mem_type, m_wdata);
            acc_err  <= req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            resp_valid <= 1'b0;
            access_err <= 1'b0;
            data_ok    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    if (req) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        access_err <= acc_err;
                        data_ok    <= !acc_err;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    dmem_bank_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (do_access),
        .we    (acc_be),
        .addr  (acc_addr),
        .wdata (acc_data),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;
    import mem_definitions::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        m_MemRead;
    logic        m_MemWrite;
    mem_mask_t   m_mem_type;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        stall_mem;
    logic [31:0] read_data;
    logic        resp_valid;
    logic        access_err;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    dmem_responder #(.ADDR_W(14), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_MemRead  (m_MemRead),
        .m_MemWrite (m_MemWrite),
        .m_mem_type (m_mem_type),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .stall_mem  (stall_mem),
        .read_data  (read_data),
        .resp_valid (resp_valid),
        .access_err (access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got resp_valid with rdata %h expected none", read_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk) check("read_data", read_data, e.data);
                check("access_err", {31'd0, access_err}, {31'd0, e.err});
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input mem_mask_t kind,
                         input logic [31:0] addr, input logic [31:0] data);
        m_MemRead  = rd;
        m_MemWrite = wr;
        m_mem_type = kind;
        m_addr     = addr;
        m_wdata    = data;
    endtask

    task automatic wait_resp(output int stalls, output int rcyc);
        bit found;
        found  = 0;
        stalls = 0;
        rcyc   = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (stall_mem) stalls++;
            if (resp_valid) begin
                rcyc  = cyc;
                found = 1;
            end
        end
        if (!found) begin
            checks++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 40 cycles");
        end
        @(posedge clk);
        #1;
        m_MemRead  = 1'b0;
        m_MemWrite = 1'b0;
    endtask

    task automatic xfer(input logic rd, input logic wr, input mem_mask_t kind,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_data, input logic exp_err, input bit chk,
                        output int rcyc);
        int stalls;
        exp_q.push_back('{data: exp_data, err: exp_err, chk: chk});
        drive(rd, wr, kind, addr, data);
        wait_resp(stalls, rcyc);
        check("stall_cycles", stalls, 3);
    endtask

    initial begin
        int r1, r2, stalls;
        rst = 1'b1;
        drive(1'b0, 1'b0, MEM_WORD, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_stall", {31'd0, stall_mem}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_access_err", {31'd0, access_err}, 32'd0);
        m_MemRead = 1'b1;
        #1;
        check("rst_stall_follows_req", {31'd0, stall_mem}, 32'd1);
        @(posedge clk);
        #1;
        m_MemRead = 1'b0;
        rst = 1'b0;

        xfer(0, 1, MEM_WORD,  32'h100,   32'hCAFEF00D, 32'h0,        0, 0, r1);
        xfer(1, 0, MEM_WORD,  32'h100,   32'h0,        32'hCAFEF00D, 0, 1, r1);
        xfer(0, 1, MEM_BYTE,  32'h103,   32'h000000AB, 32'hCAFEF00D, 0, 1, r1);
        xfer(1, 0, MEM_WORD,  32'h100,   32'h0,        32'hABFEF00D, 0, 1, r1);
        xfer(0, 1, MEM_HALF,  32'h101,   32'h0000BEEF, 32'h0,        1, 1, r1);
        xfer(1, 0, MEM_HALF,  32'h100,   32'h0,        32'hABFEF00D, 0, 1, r1);
        xfer(0, 1, MEM_UHALF, 32'h102,   32'h00001234, 32'hABFEF00D, 0, 1, r1);
        xfer(0, 1, MEM_UBYTE, 32'h101,   32'h00000077, 32'h1234F00D, 0, 1, r1);
        xfer(1, 0, MEM_WORD,  32'h100,   32'h0,        32'h1234770D, 0, 1, r1);
        xfer(1, 0, MEM_WORD,  32'h10000, 32'h0,        32'h0,        1, 1, r1);
        xfer(1, 0, MEM_WORD,  32'h102,   32'h0,        32'h0,        1, 1, r1);

        xfer(1, 0, MEM_WORD,  32'h100,   32'h0,        32'h1234770D, 0, 1, r1);
        xfer(1, 0, MEM_WORD,  32'h100,   32'h0,        32'h1234770D, 0, 1, r2);
        check("b2b_gap", r2 - r1, 4);

        xfer(0, 1, MEM_WORD,  32'h200,   32'h0,        32'h0,        0, 0, r1);
        exp_q.push_back('{data: 32'h0, err: 1'b0, chk: 1'b1});
        drive(0, 1, MEM_WORD, 32'h200, 32'h55);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wait_rst_stall", {31'd0, stall_mem}, 32'd1);
        check("wait_rst_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_resp(stalls, r1);
        check("restart_stall_cycles", stalls, 3);
        xfer(1, 0, MEM_WORD,  32'h200,   32'h0,        32'h55,       0, 1, r1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the CPU memory-stage request interface. Accepts one load or store at a time from the memory stage, holds the pipeline with `stall_mem` for a fixed number of wait states, performs a byte-enabled access to an internal word-organised RAM, and returns the full aligned read word. It lane-aligns store data, detects misaligned and out-of-range accesses, and sits between the memory stage and the data RAM in the CPU top.

## Interface
- `ADDR_W`, 14: word-address width; RAM depth is 2**ADDR_W words, byte range 0 .. 2**(ADDR_W+2)-1.
- `LATENCY`, 2: wait-state count, legal range 1..15.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m_MemRead`  in  1  load request; held stable while `stall_mem` = 1.
- `m_MemWrite`  in  1  store request; held stable while `stall_mem` = 1.
- `m_mem_type`  in  mem_mask_t  access size: MEM_BYTE, MEM_HALF, MEM_WORD, MEM_UBYTE, MEM_UHALF.
- `m_addr`  in  32  byte address.
- `m_wdata`  in  32  store data, right-justified.
- `stall_mem`  out  1  pipeline hold while a request is outstanding.
- `read_data`  out  32  full RAM word at the word address; valid in DONE.
- `resp_valid`  out  1  one-cycle completion pulse.
- `access_err`  out  1  misaligned or out-of-range, valid with `resp_valid`.

## Operation
- Request: `req = m_MemRead | m_MemWrite`. Both high is a store.
- FSM `dmem_state_t` has three states: IDLE, WAIT, DONE.
- IDLE: when `req` = 1, go to WAIT and load `wait_cnt` = LATENCY-1.
- WAIT: while `wait_cnt` != 0, decrement. When `wait_cnt` = 0, perform the access and go to DONE.
- DONE: always return to IDLE. It never accepts a request.
- `stall_mem = req & (state != DONE)`. This is combinational and is high in the same cycle the request first appears.
- `resp_valid = (state == DONE)`.
- Error check:
  - Misaligned: half-word with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr[31:ADDR_W+2] != 0.
  - On error, the write is suppressed, `read_data` = 0 and `access_err` = 1 in DONE.
- Store alignment (UBYTE/UHALF behave as BYTE/HALF):
  - Byte: data = {4{wdata[7:0]}}, be = 4'b0001 << addr[1:0].
  - Half: data = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
- Load: the whole word is registered into `read_data`. Byte/half selection and extension stay in writeback.
- Store: `read_data` returns the pre-write word, no read-after-write bypass.
- RAM contents are not affected by `rst`.

## Timing
- Request accepted in cycle 0.
- Access (RAM write, read capture) occurs at the edge ending cycle LATENCY.
- DONE is cycle LATENCY+1: `stall_mem` = 0, `resp_valid` = 1, and the memory-stage buffers advance at the edge that ends it.
- `stall_mem` is high for exactly LATENCY+1 cycles per request.
- Back-to-back requests: a new request presented in the cycle after DONE is accepted from IDLE. There are no dead cycles beyond DONE.
- Reset values: state = IDLE, `wait_cnt` = 0, `read_data` = 0, `access_err` = 0, `resp_valid` = 0.
- During reset, `stall_mem` still follows `req`.
- Reset mid-WAIT: the outstanding access is abandoned with no RAM write. A held request restarts a full LATENCY+1 sequence after reset is released.
- Request dropped during WAIT is illegal protocol. The responder still completes the access.

## Structure
- `mem_definitions` (shared package) holds `mem_mask_t` and the new `dmem_state_t`.
- Sub-module `dmem_bank_ram`:
  - Single-port, 2**ADDR_W x 32, 4-bit byte write enable, synchronous read.
  - Infers block RAM.
- The top holds the FSM, wait counter, alignment and error logic.

## Test plan
- SW 0xCAFEF00D to 0x100, then LW 0x100 → stall 3 cycles each (LATENCY = 2), read_data = 0xCAFEF00D, access_err = 0.
- After the previous store, SB 0x000000AB to 0x103, then LW 0x100 → read_data = 0xABFEF00D, and the store cycle's read_data = 0xCAFEF00D.
- SH to 0x101 → access_err = 1, RAM unchanged, read_data = 0, stall still 3 cycles.
- LW 0x0001_0000 with ADDR_W = 14 → access_err = 1, read_data = 0.
- Two consecutive LWs, the second presented in the cycle after DONE → two resp_valid pulses 4 cycles apart, no extra gap.
- Assert rst in WAIT of SW 0x55 to 0x200 with the request held → no write. After release, the request completes in 3 cycles and LW 0x200 returns 0x55.
